// File: rtl/imem_fetch_if.sv
// Bus bundle between the fetch controller, the instruction memory and decode.
// master = fetch controller side, slave = memory/decode side.
interface imem_fetch_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the async instruction memory
// and presents each word through a registered valid/ready stage to decode.
module imem_fetch_ctrl #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 6'h00,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  imem_fetch_if.master   bus,
  output logic           busy_o,
  output logic           halt_o,
  output logic [15:0]    fetch_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [15:0]       count_q, count_d;
  logic              load;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
    end
  end

  // Redirect outranks both load and consume; a held instruction is dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    count_d = count_q;
    load    = (state_q == RUN) && (!valid_q || bus.inst_ready) && !bus.redirect_valid;

    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        if (start_i) state_d = RUN;
        if (valid_q && bus.inst_ready) valid_d = 1'b0;
      end
      RUN, HALTED: begin
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = bus.redirect_pc;
          state_d = RUN;
        end else if (load) begin
          data_d  = bus.imem_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
          count_d = count_q + 16'd1;
          if (bus.imem_data == HALT_WORD) state_d = HALTED;
        end else if (valid_q && bus.inst_ready) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_data  = data_q;
  assign bus.inst_pc    = ipc_q;
  assign busy_o         = (state_q == RUN);
  assign halt_o         = (state_q == HALTED);
  assign fetch_count_o  = count_q;

endmodule
